// File: rtl/door_lock_controller_pkg.sv
// Types and helpers shared by the door lock controller and its timer.
`include "constant.vh"

package door_lock_controller_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = `DOOR_STATE_LOCKED,
        ST_UNLOCKED = `DOOR_STATE_UNLOCKED,
        ST_OCCUPIED = `DOOR_STATE_OCCUPIED,
        ST_HOLD     = `DOOR_STATE_HOLD
    } door_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/constant.vh
// Shared constants for the door lock controller: sensor width, state encodings, default code width.
`ifndef DOOR_LOCK_CONSTANT_VH
`define DOOR_LOCK_CONSTANT_VH

`define DOOR_MOTION_SENSOR_DATA_WIDTH 1

`define DOOR_STATE_LOCKED   2'd0
`define DOOR_STATE_UNLOCKED 2'd1
`define DOOR_STATE_OCCUPIED 2'd2
`define DOOR_STATE_HOLD     2'd3

`define DOOR_CODE_W_DEFAULT 16

`endif

// File: rtl/door_timer.sv
// Loadable down-counter that saturates at zero; done flags the final cycle of a loaded window.
`include "constant.vh"

module door_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // A window loaded with N ends at the edge that sees count==1, giving exactly N cycles.
    assign done = (count <= W'(1));

endmodule

// File: rtl/door_lock_controller.sv
// Door lock FSM with relock timer; optional bad-code lockout under DOOR_LOCK_LOCKOUT_EN.
`include "constant.vh"

module door_lock_controller
    import door_lock_controller_pkg::*;
#(
    parameter int                CODE_W         = `DOOR_CODE_W_DEFAULT,
    parameter logic [CODE_W-1:0] SECRET         = CODE_W'(16'h1234),
    parameter int                OPEN_CYCLES    = 100,
    parameter int                HOLD_CYCLES    = 20,
    parameter int                MAX_FAIL       = 3,
    parameter int                LOCKOUT_CYCLES = 1000
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      code_valid,
    input  logic [CODE_W-1:0]                         code_in,
    input  logic [`DOOR_MOTION_SENSOR_DATA_WIDTH-1:0] door_motion_sensor,
    input  logic                                      force_lock,
    output logic                                      lock_door,
    output logic [1:0]                                door_state,
    output logic                                      code_ok,
    output logic                                      code_bad,
    output logic                                      lockout
);

    localparam int TIMER_W = $clog2(max_int(OPEN_CYCLES, HOLD_CYCLES) + 1);

    door_state_e        state, nxt_state;
    logic               motion;
    logic               code_en, code_match;
    logic               timer_load, timer_done;
    logic [TIMER_W-1:0] timer_val;

    assign motion     = |door_motion_sensor;
    assign code_en    = (state == ST_LOCKED) && code_valid && !lockout;
    assign code_match = (code_in == SECRET);

    always_comb begin
        nxt_state = state;
        case (state)
            ST_LOCKED:   if (code_en && code_match) nxt_state = ST_UNLOCKED;
            ST_UNLOCKED: begin
                if (motion)          nxt_state = ST_OCCUPIED;
                else if (force_lock) nxt_state = ST_LOCKED;
                else if (timer_done) nxt_state = ST_LOCKED;
            end
            // force_lock deliberately ignored: never bolt the door on someone in the doorway.
            ST_OCCUPIED: if (!motion) nxt_state = ST_HOLD;
            ST_HOLD: begin
                if (motion)          nxt_state = ST_OCCUPIED;
                else if (force_lock) nxt_state = ST_LOCKED;
                else if (timer_done) nxt_state = ST_LOCKED;
            end
            default:     nxt_state = ST_LOCKED;
        endcase
    end

    // Timer reloads on every state change with the length of the window being entered.
    always_comb begin
        timer_load = (nxt_state != state);
        case (nxt_state)
            ST_UNLOCKED: timer_val = TIMER_W'(OPEN_CYCLES);
            ST_HOLD:     timer_val = TIMER_W'(HOLD_CYCLES);
            default:     timer_val = '0;
        endcase
    end

    door_timer #(.W(TIMER_W)) u_relock_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOCKED;
            lock_door <= 1'b1;
            code_ok   <= 1'b0;
            code_bad  <= 1'b0;
        end else begin
            state     <= nxt_state;
            lock_door <= (nxt_state == ST_LOCKED);
            code_ok   <= code_en && code_match;
            code_bad  <= code_en && !code_match;
        end
    end

    assign door_state = state;

`ifdef DOOR_LOCK_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LO_W   = $clog2(LOCKOUT_CYCLES + 1);

    logic [FAIL_W-1:0] fail_cnt;
    logic              lo_start, lo_done;

    // A correct code arriving in the same cycle the threshold is reached still wins.
    assign lo_start = !lockout && (fail_cnt == FAIL_W'(MAX_FAIL)) && !(code_en && code_match);

    door_timer #(.W(LO_W)) u_lockout_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lo_start),
        .load_val (LO_W'(LOCKOUT_CYCLES)),
        .done     (lo_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= '0;
            lockout  <= 1'b0;
        end else begin
            if (lo_start) begin
                lockout <= 1'b1;
            end else if (lockout && lo_done) begin
                lockout  <= 1'b0;
                fail_cnt <= '0;
            end
            if (code_en && code_match)
                fail_cnt <= '0;
            else if (code_en && fail_cnt != FAIL_W'(MAX_FAIL))
                fail_cnt <= fail_cnt + FAIL_W'(1);
        end
    end
`else
    logic lockout_cfg_unused;
    assign lockout_cfg_unused = ^{MAX_FAIL, LOCKOUT_CYCLES};
    assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_door_lock_controller.sv
// Self-checking bench for door_lock_controller: directed scenarios plus random traffic vs a reference model.
module tb_door_lock_controller;

    localparam int          OPEN   = 8;
    localparam int          HOLD   = 4;
    localparam int          MAXF   = 3;
    localparam int          LO     = 16;
    localparam logic [15:0] SECRET = 16'h1234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [15:0] code_in = '0;
    logic [0:0]  door_motion_sensor = '0;
    logic        force_lock = 1'b0;
    logic        lock_door;
    logic [1:0]  door_state;
    logic        code_ok, code_bad, lockout;

    int checks = 0;
    int errors = 0;

    door_lock_controller #(
        .CODE_W(16), .SECRET(SECRET), .OPEN_CYCLES(OPEN), .HOLD_CYCLES(HOLD),
        .MAX_FAIL(MAXF), .LOCKOUT_CYCLES(LO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_in(code_in),
        .door_motion_sensor(door_motion_sensor), .force_lock(force_lock),
        .lock_door(lock_door), .door_state(door_state), .code_ok(code_ok),
        .code_bad(code_bad), .lockout(lockout)
    );

    always #5 clk = ~clk;

    // Reference model: state name, cycles left in the current timed window, fail tally, lockout time left.
    int m_state, m_left, m_fails, m_lock_left;
    bit m_ok, m_bad, m_lockout;

    task automatic model_reset();
        m_state = 0; m_left = 0; m_fails = 0; m_lock_left = 0;
        m_ok = 0; m_bad = 0; m_lockout = 0;
    endtask

    task automatic model_step(input bit cv, input logic [15:0] code, input bit mot, input bit frc);
        bit accept, good, prev_lock;
        int prev_fails;
        accept     = (m_state == 0) && cv && !m_lockout;
        good       = accept && (code == SECRET);
        m_ok       = good;
        m_bad      = accept && !good;
        prev_lock  = m_lockout;
        prev_fails = m_fails;
        case (m_state)
            0: if (good) begin m_state = 1; m_left = OPEN; end
            1: if (mot) m_state = 2;
               else if (frc) m_state = 0;
               else begin m_left--; if (m_left == 0) m_state = 0; end
            2: if (!mot) begin m_state = 3; m_left = HOLD; end
            default: if (mot) m_state = 2;
               else if (frc) m_state = 0;
               else begin m_left--; if (m_left == 0) m_state = 0; end
        endcase
`ifdef DOOR_LOCK_LOCKOUT_EN
        if (good) m_fails = 0;
        else if (m_bad && m_fails < MAXF) m_fails++;
        if (prev_lock) begin
            m_lock_left--;
            if (m_lock_left == 0) begin m_lockout = 0; m_fails = 0; end
        end else if (prev_fails == MAXF && !good) begin
            m_lockout = 1; m_lock_left = LO;
        end
`else
        prev_fails = prev_fails + int'(prev_lock);
`endif
    endtask

    function automatic logic [5:0] exp_vec();
        return {m_state == 0, 2'(m_state), m_ok, m_bad, m_lockout};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {lock_door, door_state, code_ok, code_bad, lockout};
    endfunction

    task automatic tick(input bit cv, input logic [15:0] code, input bit mot, input bit frc);
        code_valid = cv; code_in = code; door_motion_sensor = mot; force_lock = frc;
        @(posedge clk);
        model_step(cv, code, mot, frc);
        #1;
    endtask

    task automatic do_reset();
        code_valid = 0; code_in = '0; door_motion_sensor = '0; force_lock = 0;
        rst_n = 0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 6'b100000) begin
            errors++; $display("FAIL reset_state: got %b exp %b", dut_vec(), 6'b100000);
        end
    endtask

    task automatic test_unlock_timeout();
        int lock_at;
        do_reset();
        tick(1, SECRET, 0, 0);
        checks++;
        if (code_ok !== 1'b1 || lock_door !== 1'b0) begin
            errors++; $display("FAIL unlock_latency: ok=%b lock=%b exp ok=1 lock=0", code_ok, lock_door);
        end
        lock_at = 0;
        for (int i = 2; i <= 12; i++) begin
            tick(0, '0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL unlock_timeout cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
            if (lock_at == 0 && lock_door === 1'b1) lock_at = i;
        end
        checks++;
        if (lock_at != OPEN + 1) begin
            errors++; $display("FAIL relock_edge: got N+%0d exp N+%0d", lock_at, OPEN + 1);
        end
    endtask

    task automatic test_bad_code();
        do_reset();
        tick(1, 16'h0BAD, 0, 0);
        checks++;
        if ({code_ok, code_bad, lock_door, door_state} !== 5'b01100) begin
            errors++; $display("FAIL bad_code: got %b exp %b", {code_ok, code_bad, lock_door, door_state}, 5'b01100);
        end
        tick(0, '0, 0, 0);
        checks++;
        if (code_bad !== 1'b0) begin
            errors++; $display("FAIL bad_pulse_width: got %b exp 0", code_bad);
        end
    endtask

    task automatic test_occupied();
        int unlocked_ticks;
        bit early_lock;
        do_reset();
        tick(1, SECRET, 0, 0);
        early_lock = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, '0, (i >= 2), (i >= 4));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL occupied cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
            if (lock_door !== 1'b0) early_lock = 1;
        end
        checks++;
        if (early_lock || door_state !== 2'd2) begin
            errors++; $display("FAIL occupied_force: early_lock=%0d state=%0d exp 0/2", early_lock, door_state);
        end
        unlocked_ticks = 0;
        for (int i = 0; i < 10 && lock_door !== 1'b1; i++) begin
            tick(0, '0, 0, 0);
            unlocked_ticks++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL hold_relock cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (unlocked_ticks != HOLD + 1) begin
            errors++; $display("FAIL hold_length: got %0d exp %0d", unlocked_ticks, HOLD + 1);
        end
    endtask

    task automatic test_hold_reentry();
        int hold_ticks;
        do_reset();
        tick(1, SECRET, 0, 0);
        tick(0, '0, 1, 0);
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);
        tick(0, '0, 1, 0);
        checks++;
        if (door_state !== 2'd2 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL hold_reentry: got %b exp %b", dut_vec(), exp_vec());
        end
        tick(0, '0, 0, 0);
        hold_ticks = 0;
        for (int i = 0; i < 10 && lock_door !== 1'b1; i++) begin
            tick(0, '0, 0, 0);
            hold_ticks++;
        end
        checks++;
        if (hold_ticks != HOLD) begin
            errors++; $display("FAIL hold_reload: got %0d exp %0d", hold_ticks, HOLD);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        tick(0, '0, 0, 1);
        tick(0, '0, 0, 1);
        checks++;
        if (lock_door !== 1'b1 || door_state !== 2'd0) begin
            errors++; $display("FAIL force_in_locked: lock=%b state=%0d exp 1/0", lock_door, door_state);
        end
        tick(1, SECRET, 0, 0);
        tick(1, SECRET, 0, 0);
        checks++;
        if (code_ok !== 1'b0 || code_bad !== 1'b0 || door_state !== 2'd1) begin
            errors++; $display("FAIL code_in_unlocked: ok=%b bad=%b state=%0d exp 0/0/1", code_ok, code_bad, door_state);
        end
        tick(0, '0, 0, 1);
        checks++;
        if (dut_vec() !== exp_vec() || lock_door !== 1'b1) begin
            errors++; $display("FAIL force_unlocked: got %b exp %b", dut_vec(), exp_vec());
        end
    endtask

`ifdef DOOR_LOCK_LOCKOUT_EN
    task automatic test_lockout();
        int lo_len;
        do_reset();
        for (int i = 0; i < MAXF; i++) begin
            tick(1, 16'h0000, 0, 0);
            checks++;
            if (code_bad !== 1'b1) begin
                errors++; $display("FAIL lockout_bad_%0d: got %b exp 1", i, code_bad);
            end
            tick(0, '0, 0, 0);
        end
        checks++;
        if (lockout !== 1'b1) begin
            errors++; $display("FAIL lockout_assert: got %b exp 1", lockout);
        end
        tick(1, SECRET, 0, 0);
        checks++;
        if (code_ok !== 1'b0 || lock_door !== 1'b1) begin
            errors++; $display("FAIL lockout_ignore: ok=%b lock=%b exp 0/1", code_ok, lock_door);
        end
        lo_len = 2;
        for (int i = 0; i < 40 && lockout === 1'b1; i++) begin
            tick(0, '0, 0, 0);
            if (lockout === 1'b1) lo_len++;
        end
        checks++;
        if (lo_len != LO) begin
            errors++; $display("FAIL lockout_length: got %0d exp %0d", lo_len, LO);
        end
        tick(1, SECRET, 0, 0);
        checks++;
        if (code_ok !== 1'b1 || lock_door !== 1'b0) begin
            errors++; $display("FAIL lockout_recover: ok=%b lock=%b exp 1/0", code_ok, lock_door);
        end
    endtask
`endif

    task automatic test_async_reset();
        int open_ticks;
        do_reset();
        tick(1, SECRET, 0, 0);
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (lock_door !== 1'b1 || door_state !== 2'd0 || code_ok !== 1'b0) begin
            errors++; $display("FAIL async_reset: lock=%b state=%0d ok=%b exp 1/0/0", lock_door, door_state, code_ok);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick(1, SECRET, 0, 0);
        checks++;
        if (code_ok !== 1'b1 || door_state !== 2'd1) begin
            errors++; $display("FAIL first_code_after_reset: ok=%b state=%0d exp 1/1", code_ok, door_state);
        end
        open_ticks = 0;
        for (int i = 0; i < 20 && lock_door !== 1'b1; i++) begin
            tick(0, '0, 0, 0);
            open_ticks++;
        end
        checks++;
        if (open_ticks != OPEN) begin
            errors++; $display("FAIL fresh_window: got %0d exp %0d", open_ticks, OPEN);
        end
    endtask

    task automatic test_random();
        bit mot, cv, frc;
        logic [15:0] code;
        do_reset();
        mot = 0;
        for (int i = 0; i < 600; i++) begin
            cv   = ($urandom_range(0, 2) == 0);
            code = ($urandom_range(0, 2) == 0) ? SECRET : 16'($urandom);
            if ($urandom_range(0, 5) == 0) mot = ~mot;
            frc  = ($urandom_range(0, 6) == 0);
            tick(cv, code, mot, frc);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_unlock_timeout();
        test_bad_code();
        test_occupied();
        test_hold_reentry();
        test_ignored();
`ifdef DOOR_LOCK_LOCKOUT_EN
        test_lockout();
`endif
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
